// File: rtl/aes_term_skid_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_term_skid_stage: 2-entry in-order skid buffer in front of the term decode cone.
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_term_skid_stage #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [1:0]       C_OCC_EMPTY = 2'd0;
  localparam logic [1:0]       C_OCC_FULL  = 2'd2;
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_slot0;
  logic [WIDTH-1:0] r_slot1;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_xfer_count;

  logic w_push;
  logic w_pop;
  logic w_wr_ptr;

  // Ready is a function of occupancy only, so upstream never sees out_ready.
  assign in_ready   = (r_occ < C_OCC_FULL) && !flush && rst_n;
  assign out_valid  = (r_occ != C_OCC_EMPTY);
  assign out_data   = r_rd_ptr ? r_slot1 : r_slot0;
  assign xfer_count = r_xfer_count;

  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_wr_ptr = r_rd_ptr ^ r_occ[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ    <= C_OCC_EMPTY;
      r_rd_ptr <= 1'b0;
    end else begin
      if (flush) begin
        r_occ <= C_OCC_EMPTY;
      end else if (w_push && !w_pop) begin
        r_occ <= r_occ + 2'd1;
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= !r_rd_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (w_push) begin
      if (w_wr_ptr) begin
        r_slot1 <= in_data;
      end else begin
        r_slot0 <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count <= '0;
    end else if (w_pop && (r_xfer_count != C_CNT_MAX)) begin
      r_xfer_count <= r_xfer_count + C_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_term_skid_stage.sv
`default_nettype none
// tb_aes_term_skid_stage: table vectors, directed corner sequences and random traffic vs. a queue model.
module tb_aes_term_skid_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic       flush;
  logic [15:0] xfer_count;

  logic       in_ready4;
  logic       out_valid4;
  logic [8:0] out_data4;
  logic [3:0] xfer_count4;

  aes_term_skid_stage #(.WIDTH(9), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .xfer_count(xfer_count)
  );

  // Narrow-counter instance shares all stimulus to exercise saturation.
  aes_term_skid_stage #(.WIDTH(9), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .flush(flush), .xfer_count(xfer_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [8:0] q[$];
  int         n_pops = 0;

  typedef struct {
    logic       iv;
    logic [8:0] d;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [8:0] e_od;
    int         e_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [8:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #2;
  endtask

  task automatic check_model();
    int e16;
    int e4;
    e16 = (n_pops > 65535) ? 65535 : n_pops;
    e4  = (n_pops > 15) ? 15 : n_pops;
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) && !flush));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
    chk("xfer_count", 32'(xfer_count), 32'(e16));
    chk("xfer_count4", 32'(xfer_count4), 32'(e4));
  endtask

  task automatic tick();
    logic       do_pop;
    logic       do_push;
    logic       fl;
    logic [8:0] d;
    do_pop  = (q.size() > 0) && out_ready;
    do_push = in_valid && (q.size() < 2) && !flush;
    fl      = flush;
    d       = in_data;
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(q.pop_front());
      n_pops++;
    end
    if (fl) q.delete();
    else if (do_push) q.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    q.delete();
    n_pops = 0;
  endtask

  initial begin
    int         c_before;
    logic [8:0] rd;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset values, held across an edge
    #3;
    chk("por_out_valid", 32'(out_valid), 32'd0);
    chk("por_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #3;
    chk("por_in_ready", 32'(in_ready), 32'd0);
    chk("por_xfer_count", 32'(xfer_count), 32'd0);
    rst_n = 1'b1;

    // Single transfer of 0x1A5
    drive(1'b1, 9'h1A5, 1'b1, 1'b0);
    chk("first_in_ready", 32'(in_ready), 32'd1);
    check_model();
    tick();
    drive(1'b0, 9'h000, 1'b1, 1'b0);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data", 32'(out_data), 32'h1A5);
    check_model();
    tick();
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    chk("single_count", 32'(xfer_count), 32'd1);
    check_model();
    tick();

    // Fill / backpressure / simultaneous push-pop table
    do_reset();
    tbl[0] = '{1'b1, 9'h001, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 0};
    tbl[1] = '{1'b1, 9'h002, 1'b0, 1'b0, 1'b1, 1'b1, 9'h001, 0};
    tbl[2] = '{1'b1, 9'h003, 1'b0, 1'b0, 1'b0, 1'b1, 9'h001, 0};
    tbl[3] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001, 0};
    tbl[4] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1, 9'h002, 1};
    tbl[5] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 2};
    tbl[6] = '{1'b1, 9'h0AA, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 2};
    tbl[7] = '{1'b1, 9'h0BB, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0AA, 2};
    tbl[8] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0BB, 3};
    tbl[9] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0BB, 3};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("tbl%0d_count", i), 32'(xfer_count), 32'(tbl[i].e_cnt));
      check_model();
      tick();
    end

    // Streaming: 100 incrementing vectors, then one drain cycle
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 9'(i), 1'b1, 1'b0);
      check_model();
      tick();
    end
    drive(1'b0, 9'h000, 1'b1, 1'b0);
    check_model();
    tick();
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    chk("stream_count", 32'(xfer_count), 32'd100);
    chk("sat_count4", 32'(xfer_count4), 32'd15);
    check_model();
    tick();

    // Flush at occ=2 without a pop
    drive(1'b1, 9'h101, 1'b0, 1'b0); check_model(); tick();
    drive(1'b1, 9'h102, 1'b0, 1'b0); check_model(); tick();
    c_before = int'(xfer_count);
    drive(1'b1, 9'h155, 1'b0, 1'b1);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    check_model();
    tick();
    drive(1'b0, 9'h000, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_count", 32'(xfer_count), 32'(c_before));
    check_model();
    tick();

    // Flush coinciding with a pop still counts the pop
    drive(1'b1, 9'h0C3, 1'b0, 1'b0); check_model(); tick();
    drive(1'b1, 9'h0C4, 1'b1, 1'b1); check_model(); tick();
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    chk("flush_pop_count", 32'(xfer_count), 32'(c_before + 1));
    check_model();
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rd = 9'($urandom_range(511, 0));
      drive(($urandom_range(3, 0) != 0), rd, ($urandom_range(2, 0) != 0),
            ($urandom_range(15, 0) == 0));
      check_model();
      tick();
    end

    // Asynchronous reset between edges with occ=1
    drive(1'b0, 9'h000, 1'b0, 1'b0); check_model(); tick();
    drive(1'b0, 9'h000, 1'b0, 1'b0); check_model(); tick();
    drive(1'b1, 9'h077, 1'b0, 1'b0); check_model(); tick();
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    chk("pre_arst_out_valid", 32'(out_valid), 32'd1);
    check_model();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(xfer_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    q.delete();
    n_pops = 0;
    #1;
    chk("post_arst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 9'(9'h1F0 + i), (i > 1), 1'b0);
      check_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
